// File: rtl/qdec_dial_counter.sv
// Quadrature decoder and wrapping position counter for the safe dial.
// Optional index/home input enabled by defining QDEC_INDEX_EN.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   a, b      : raw encoder channels (asynchronous)
//   z, idx    : index input / index pulse (QDEC_INDEX_EN only)
//   clr       : synchronous clear of cnt
//   cnt       : dial position 0..CNT_MAX
//   step      : 1-cycle pulse on a counted step
//   up        : direction of the last counted step (1 = CW)
//   dirch     : 1-cycle pulse when the counted direction reverses
//   err       : 1-cycle pulse on an illegal (two-bit) transition
module qdec_dial_counter #(
    parameter int CNT_W   = 7,
    parameter int CNT_MAX = 99,
    parameter int DEB_LEN = 4,
    parameter int MODE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
`ifdef QDEC_INDEX_EN
    input  logic             z,
    output logic             idx,
`endif
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             step,
    output logic             up,
    output logic             dirch,
    output logic             err
);

`ifdef QDEC_INDEX_EN
    localparam int NP = 3;
    // Index idles low; encoder pins idle high at the detent.
    localparam logic [NP-1:0] RV = 3'b011;
`else
    localparam int NP = 2;
    localparam logic [NP-1:0] RV = 2'b11;
`endif

    localparam int DW = (DEB_LEN < 2) ? 1 : $clog2(DEB_LEN + 1);
    localparam logic [DW-1:0]    DLAST = DW'(DEB_LEN - 1);
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(CNT_MAX);

    logic [NP-1:0] pin, s1, s2, f;
    logic [DW-1:0] dc [NP];

`ifdef QDEC_INDEX_EN
    assign pin = {z, a, b};
`else
    assign pin = {a, b};
`endif

    // Synchroniser and per-pin debounce: a pin updates its filtered
    // value only after DEB_LEN consecutive clocks of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RV;
            s2 <= RV;
            f  <= RV;
            for (int i = 0; i < NP; i++) dc[i] <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            for (int i = 0; i < NP; i++) begin
                if (s2[i] == f[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DLAST) begin
                    f[i]  <= s2[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0]       ps, cs;
    logic             cw, ccw, bad, hit;
    logic [CNT_W-1:0] nxt;

    assign cs = f[1:0];

    // CW order is 11 -> 01 -> 00 -> 10 -> 11.
    always_comb begin
        cw  = (ps == 2'b11 && cs == 2'b01) || (ps == 2'b01 && cs == 2'b00) ||
              (ps == 2'b00 && cs == 2'b10) || (ps == 2'b10 && cs == 2'b11);
        ccw = (ps == 2'b01 && cs == 2'b11) || (ps == 2'b00 && cs == 2'b01) ||
              (ps == 2'b10 && cs == 2'b00) || (ps == 2'b11 && cs == 2'b10);
        bad = (ps ^ cs) == 2'b11;
        if (MODE == 1)      hit = (cw | ccw) && (cs == 2'b11);
        else if (MODE == 2) hit = (cw | ccw) && (ps[1] != cs[1]);
        else                hit = cw | ccw;
        if (cw) nxt = (cnt == TOP) ? '0 : cnt + 1'b1;
        else    nxt = (cnt == '0) ? TOP : cnt - 1'b1;
    end

`ifdef QDEC_INDEX_EN
    logic zd;
    logic zrise;
    assign zrise = f[2] & ~zd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps    <= 2'b11;
            cnt   <= '0;
            step  <= 1'b0;
            up    <= 1'b1;
            dirch <= 1'b0;
            err   <= 1'b0;
`ifdef QDEC_INDEX_EN
            zd    <= 1'b0;
            idx   <= 1'b0;
`endif
        end else begin
            ps    <= cs;
            step  <= 1'b0;
            dirch <= 1'b0;
            err   <= bad;
`ifdef QDEC_INDEX_EN
            zd    <= f[2];
            idx   <= 1'b0;
            if (zrise) begin
                cnt <= '0;
                idx <= 1'b1;
            end else
`endif
            if (clr) begin
                cnt <= '0;
            end else if (hit) begin
                cnt   <= nxt;
                step  <= 1'b1;
                up    <= cw;
                dirch <= (cw != up);
            end
        end
    end

endmodule

// File: tb/tb_qdec_dial_counter.sv
// Directed bench for qdec_dial_counter: one x4 and one x1 instance
// share the same encoder stimulus.
module tb_qdec_dial_counter;

    logic clk = 1'b0;
    logic rst, a, b, clr;
    logic [6:0] cnt4, cnt1;
    logic step4, up4, dirch4, err4;
    logic step1, up1, dirch1, err1;

    int npass = 0;
    int ntot  = 0;
    int st4 = 0, dc4 = 0, er4 = 0, st1 = 0;
    int s0, d0, e0, lat;

    always #5 clk = ~clk;

    qdec_dial_counter #(.MODE(4)) u4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .cnt(cnt4), .step(step4), .up(up4), .dirch(dirch4), .err(err4)
    );

    qdec_dial_counter #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .cnt(cnt1), .step(step1), .up(up1), .dirch(dirch1), .err(err1)
    );

    always @(negedge clk) begin
        if (step4)  st4++;
        if (dirch4) dc4++;
        if (err4)   er4++;
        if (step1)  st1++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ab(input logic [1:0] v, input int n);
        a = v[1];
        b = v[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic cwcyc();
        ab(2'b01, 10); ab(2'b00, 10); ab(2'b10, 10); ab(2'b11, 10);
    endtask

    task automatic ccwcyc();
        ab(2'b10, 10); ab(2'b00, 10); ab(2'b01, 10); ab(2'b11, 10);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; a = 1'b1; b = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cnt",   cnt4,   0);
        chk("rst_step",  step4,  0);
        chk("rst_up",    up4,    1);
        chk("rst_dirch", dirch4, 0);
        chk("rst_err",   err4,   0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: full CW cycle, x4
        s0 = st4; d0 = dc4; e0 = er4;
        a = 1'b0; lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (step4 && lat < 0) lat = k;
        end
        chk("t1_latency", lat, 7);
        ab(2'b00, 10); ab(2'b10, 10); ab(2'b11, 10);
        chk("t1_steps", st4 - s0, 4);
        chk("t1_cnt",   cnt4, 4);
        chk("t1_up",    up4, 1);
        chk("t1_dirch", dc4 - d0, 0);
        chk("t1_err",   er4 - e0, 0);

        // 2: CCW from 0 wraps to 99
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("t2_clr", cnt4, 0);
        d0 = dc4;
        ab(2'b10, 10);
        chk("t2_cnt",   cnt4, 99);
        chk("t2_up",    up4, 0);
        chk("t2_dirch", dc4 - d0, 1);
        ab(2'b11, 10);
        chk("t2_wrap_back", cnt4, 0);
        chk("t2_up_back",   up4, 1);

        // 3: 3-clock glitch is filtered
        s0 = st4; e0 = er4;
        a = 1'b0;
        repeat (3) @(negedge clk);
        a = 1'b1;
        repeat (12) @(negedge clk);
        chk("t3_steps", st4 - s0, 0);
        chk("t3_err",   er4 - e0, 0);
        chk("t3_cnt",   cnt4, 0);

        // 4: two-bit jumps
        s0 = st4; e0 = er4;
        ab(2'b00, 15);
        chk("t4_err1", er4 - e0, 1);
        chk("t4_cnt",  cnt4, 0);
        chk("t4_up",   up4, 1);
        ab(2'b11, 15);
        chk("t4_err2",  er4 - e0, 2);
        chk("t4_steps", st4 - s0, 0);

        // 5: x1 mode counts and wraps
        do_rst();
        s0 = st1;
        cwcyc(); cwcyc();
        chk("t5_cnt1",  cnt1, 2);
        chk("t5_steps", st1 - s0, 2);
        chk("t5_cnt4",  cnt4, 8);
        ccwcyc(); ccwcyc(); ccwcyc(); ccwcyc();
        chk("t5_cnt98", cnt1, 98);
        cwcyc();
        chk("t5_cnt99", cnt1, 99);
        cwcyc();
        chk("t5_wrap0", cnt1, 0);
        chk("t5_up",    up1, 1);

        // 6: clr beats a coincident step; async reset
        do_rst();
        cwcyc();
        chk("t6_pre", cnt4, 4);
        a = 1'b0;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_cnt",  cnt4, 0);
        chk("t6_clr_step", step4, 0);
        chk("t6_clr_up",   up4, 1);
        clr = 1'b0;
        repeat (10) @(negedge clk);
        ab(2'b11, 10);
        chk("t6_ccw_cnt", cnt4, 99);
        chk("t6_ccw_up",  up4, 0);
        a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt",   cnt4, 0);
        chk("t6_rst_up",    up4, 1);
        chk("t6_rst_step",  step4, 0);
        chk("t6_rst_dirch", dirch4, 0);
        chk("t6_rst_err",   err4, 0);
        @(negedge clk);
        rst = 1'b0;
        a = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
